rram_host_ctrl: RTL and testbench
=================================

Name: rram_host_ctrl

Overview:
- Host-side initiator for the RRAM_digital serial/nibble interface; the other end of that device port.
- Converts a single-word request (read or write, 12-bit address, 32-bit data) into the CE/CLE/ALE/WE/RE strobe sequence, nibble command/address on IO, and serial data on Dinout.
- Waits on RB, then returns a one-cycle response.
- Sits between the system bus adapter and the RRAM macro top level; the top level owns the tristate buffers for IO and Dinout.

Parameters:
- CMD_WRITE, 4'b0100, write command nibble
- CMD_WRITE_CONFIRM, 4'b0010, write confirm nibble issued after data
- CMD_READ, 4'b0001, read command nibble
- RB_GUARD, 2, cycles RB is ignored after confirm or read address, so the device can drop RB
- TIMEOUT_CYCLES, 1024, RB wait limit; used only with BUSY_TIMEOUT_EN

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer when req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  12  {block[1:0], row[4:0], col[4:0]}
- req_wdata  in  32  write word, sent MSB first
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read word; holds last value until the next read completes
- rsp_err  out  1  valid with rsp_valid; RB timeout
- CE  out  1  chip enable, active low
- CLE  out  1  command latch enable
- ALE  out  1  address latch enable
- WE  out  1  write strobe; device latches while high
- RE  out  1  read strobe
- IO_out  out  4  command/address nibble
- IO_oe  out  1  IO drive enable
- Din_out  out  1  serial write bit
- Din_oe  out  1  Dinout drive enable
- Din_in  in  1  serial read bit from Dinout
- RB  in  1  device ready (1) / busy (0)

Behaviour:
- Reset values:
  - CE=1; CLE=ALE=WE=RE=0; IO_out=0; IO_oe=0; Din_out=0; Din_oe=0
  - req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0
- Reset mid-operation: outputs take reset values on the next edge, the FSM goes to IDLE, and no rsp_valid is issued.
- Accept: on the edge where req_valid & req_ready, latch write/addr/wdata; req_ready=0 until the FSM returns to IDLE.
- Cycle budget after accept:
  - CE_SETUP (1 cycle): CE=0; CE stays 0 until DONE.
  - CMD (3 cycles):
    - cycle 1: CLE=1, IO_oe=1, IO_out=cmd
    - cycle 2: WE=1
    - cycle 3: WE=0, CLE=0
  - ADDR (7 cycles): ALE=1; for nibbles addr[11:8], addr[7:4], addr[3:0]: one cycle with IO_out=nibble and WE=0, then one cycle with WE=1; then one cycle ALE=0, IO_oe=0.
  - WDATA (write only, 64 cycles): Din_oe=1; for bits 31..0: one cycle with Din_out=bit and WE=0, then one cycle with WE=1; Din_out is stable across both cycles; Din_oe=0 after the last bit.
  - CONFIRM (write only, 3 cycles): same as CMD with CMD_WRITE_CONFIRM.
  - WAIT_RB: RB ignored for RB_GUARD cycles, then leave the state on the first cycle RB=1 is sampled.
  - RDATA (read only, 64 cycles): for bits 31..0: one cycle RE=1, then one cycle RE=0; Din_in is sampled into a shift register on the edge that ends the RE=1 cycle; Din_oe stays 0.
  - DONE (1 cycle): CE=1, rsp_valid=1; rsp_rdata updated (reads only); then IDLE.
- States: IDLE, CE_SETUP, CMD, ADDR, WDATA, CONFIRM, WAIT_RB, RDATA, DONE.
  - Write path: IDLE>CE_SETUP>CMD>ADDR>WDATA>CONFIRM>WAIT_RB>DONE.
  - Read path: IDLE>CE_SETUP>CMD>ADDR>WAIT_RB>RDATA>DONE.
- Latency with RB=1 throughout, accept edge to rsp_valid edge:
  - write = 1+3+7+64+3+RB_GUARD+1 = 81
  - read = 1+3+7+RB_GUARD+64+1 = 78
- Never drive IO_oe and Din_oe simultaneously; WE and RE are never high together; strobes are exactly one cycle wide.
- req_valid is ignored while req_ready=0. A new request can be accepted in the cycle after DONE.

Optional Feature:
BUSY_TIMEOUT_EN:
- When defined, a counter runs in WAIT_RB. If RB is still 0 after TIMEOUT_CYCLES cycles, go to DONE with rsp_err=1 and skip RDATA; rsp_rdata is unchanged.
- When not defined, WAIT_RB waits indefinitely and rsp_err is tied to 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> CE=1, all strobes 0, req_ready=1, no accept.
- Write, addr=12'h081, wdata=32'hA5D6ACB5, RB=1 -> IO nibbles 0100 (CLE), 0000/1000/0001 (ALE) each with one WE pulse; 32 WE-high data bits match wdata MSB first; then 0010 confirm; rsp_valid at cycle 81; rsp_err=0.
- Write with device RB=0 for 20 cycles after confirm -> rsp_valid delayed by exactly 20-RB_GUARD cycles versus the RB=1 case; CE stays 0 throughout.
- Read, addr=12'hFFF, model drives Din_in with 32'h12345678 MSB first per RE pulse -> rsp_rdata=32'h12345678 at cycle 78; Din_oe=0 throughout.
- Reset asserted during WDATA bit 10 -> next edge: CE=1, Din_oe=0, no rsp_valid; a following read then completes normally.
- BUSY_TIMEOUT_EN with TIMEOUT_CYCLES=16 and RB stuck at 0 on a read -> rsp_valid with rsp_err=1, no RE pulses, rsp_rdata unchanged.

Source files
------------

// File: rtl/rram_host_ctrl.sv
// rram_host_ctrl: host-side initiator that turns single-word requests into the RRAM strobe/nibble/serial sequence.
// Define BUSY_TIMEOUT_EN to bound the RB wait by TIMEOUT_CYCLES and report rsp_err on expiry.
module rram_host_ctrl #(
    parameter logic [3:0]  CMD_WRITE         = 4'b0100,
    parameter logic [3:0]  CMD_WRITE_CONFIRM = 4'b0010,
    parameter logic [3:0]  CMD_READ          = 4'b0001,
    parameter int unsigned RB_GUARD          = 2,
    parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        CE,
    output logic        CLE,
    output logic        ALE,
    output logic        WE,
    output logic        RE,
    output logic [3:0]  IO_out,
    output logic        IO_oe,
    output logic        Din_out,
    output logic        Din_oe,
    input  logic        Din_in,
    input  logic        RB
);

    // Counter must span the 64-cycle data phases and, when enabled, the RB timeout.
    localparam int CNT_W = (TIMEOUT_CYCLES > 64) ? $clog2(TIMEOUT_CYCLES + 1) : 7;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CE_SETUP = 4'd1,
        CMD      = 4'd2,
        ADDR     = 4'd3,
        WDATA    = 4'd4,
        CONFIRM  = 4'd5,
        WAIT_RB  = 4'd6,
        RDATA    = 4'd7,
        DONE     = 4'd8
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               write_r;
    logic [11:0]        addr_r;
    logic [31:0]        wdata_r;
    logic [31:0]        shift_r;
    logic               accept_s;
    logic               guard_done_s;
    logic               timeout_s;

    logic               ce_s, cle_s, ale_s, we_s, re_s;
    logic [3:0]         io_out_s;
    logic               io_oe_s, din_out_s, din_oe_s;
    logic               req_ready_s, rsp_valid_s;

    // Next-state and phase counter.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        accept_s     = req_valid && req_ready;
        guard_done_s = ((cnt_r + CNT_W'(1)) >= CNT_W'(RB_GUARD));
`ifdef BUSY_TIMEOUT_EN
        timeout_s    = (state_r == WAIT_RB) && !RB && ((cnt_r + CNT_W'(1)) >= CNT_W'(TIMEOUT_CYCLES));
`else
        timeout_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = CE_SETUP;
                    cnt_s   = CNT_W'(0);
                end else begin
                    state_s = IDLE;
                end
            end
            CE_SETUP: begin
                state_s = CMD;
                cnt_s   = CNT_W'(0);
            end
            CMD: begin
                if (cnt_r == CNT_W'(2)) begin
                    state_s = ADDR;
                    cnt_s   = CNT_W'(0);
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ADDR: begin
                if (cnt_r == CNT_W'(6)) begin
                    state_s = write_r ? WDATA : WAIT_RB;
                    cnt_s   = CNT_W'(0);
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            WDATA: begin
                if (cnt_r == CNT_W'(63)) begin
                    state_s = CONFIRM;
                    cnt_s   = CNT_W'(0);
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            CONFIRM: begin
                if (cnt_r == CNT_W'(2)) begin
                    state_s = WAIT_RB;
                    cnt_s   = CNT_W'(0);
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            WAIT_RB: begin
                // RB is only trusted once the device has had time to pull it low.
                if (guard_done_s && RB) begin
                    state_s = write_r ? DONE : RDATA;
                    cnt_s   = CNT_W'(0);
                end else if (timeout_s) begin
                    state_s = DONE;
                    cnt_s   = CNT_W'(0);
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            RDATA: begin
                if (cnt_r == CNT_W'(63)) begin
                    state_s = DONE;
                    cnt_s   = CNT_W'(0);
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
                cnt_s   = CNT_W'(0);
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_W'(0);
            end
        endcase
    end

    // Output decode from the upcoming state so every pin is a flop aligned with its state.
    always_comb begin
        ce_s        = 1'b1;
        cle_s       = 1'b0;
        ale_s       = 1'b0;
        we_s        = 1'b0;
        re_s        = 1'b0;
        io_out_s    = 4'd0;
        io_oe_s     = 1'b0;
        din_out_s   = 1'b0;
        din_oe_s    = 1'b0;
        req_ready_s = (state_s == IDLE);
        rsp_valid_s = (state_s == DONE);
        case (state_s)
            IDLE: begin
                ce_s = 1'b1;
            end
            CE_SETUP: begin
                ce_s = 1'b0;
            end
            CMD, CONFIRM: begin
                ce_s     = 1'b0;
                io_oe_s  = 1'b1;
                io_out_s = (state_s == CONFIRM) ? CMD_WRITE_CONFIRM : (write_r ? CMD_WRITE : CMD_READ);
                cle_s    = (cnt_s != CNT_W'(2));
                we_s     = (cnt_s == CNT_W'(1));
            end
            ADDR: begin
                ce_s = 1'b0;
                if (cnt_s == CNT_W'(6)) begin
                    ale_s   = 1'b0;
                    io_oe_s = 1'b0;
                end else begin
                    ale_s   = 1'b1;
                    io_oe_s = 1'b1;
                    we_s    = cnt_s[0];
                    case (cnt_s[2:1])
                        2'd0:    io_out_s = addr_r[11:8];
                        2'd1:    io_out_s = addr_r[7:4];
                        default: io_out_s = addr_r[3:0];
                    endcase
                end
            end
            WDATA: begin
                ce_s      = 1'b0;
                din_oe_s  = 1'b1;
                din_out_s = wdata_r[5'd31 - cnt_s[5:1]];
                we_s      = cnt_s[0];
            end
            WAIT_RB: begin
                ce_s = 1'b0;
            end
            RDATA: begin
                ce_s = 1'b0;
                re_s = ~cnt_s[0];
            end
            DONE: begin
                ce_s = 1'b1;
            end
            default: begin
                ce_s = 1'b1;
            end
        endcase
    end

    // State, request capture, read shift register and registered pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_W'(0);
            write_r   <= 1'b0;
            addr_r    <= 12'd0;
            wdata_r   <= 32'd0;
            shift_r   <= 32'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            CE        <= 1'b1;
            CLE       <= 1'b0;
            ALE       <= 1'b0;
            WE        <= 1'b0;
            RE        <= 1'b0;
            IO_out    <= 4'd0;
            IO_oe     <= 1'b0;
            Din_out   <= 1'b0;
            Din_oe    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                write_r <= req_write;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            // Din_in is captured on the edge closing each RE-high cycle.
            if ((state_r == RDATA) && !cnt_r[0]) begin
                shift_r <= {shift_r[30:0], Din_in};
            end
            if ((state_r == RDATA) && (state_s == DONE)) begin
                rsp_rdata <= shift_r;
            end
            rsp_err   <= timeout_s;
            req_ready <= req_ready_s;
            rsp_valid <= rsp_valid_s;
            CE        <= ce_s;
            CLE       <= cle_s;
            ALE       <= ale_s;
            WE        <= we_s;
            RE        <= re_s;
            IO_out    <= io_out_s;
            IO_oe     <= io_oe_s;
            Din_out   <= din_out_s;
            Din_oe    <= din_oe_s;
        end
    end

endmodule

// File: tb/tb_rram_host_ctrl.sv
// tb_rram_host_ctrl: directed bench for rram_host_ctrl with a small device model driving RB and Din_in.
// Define BUSY_TIMEOUT_EN to also exercise the RB timeout path (TIMEOUT_CYCLES=16).
module tb_rram_host_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        CE, CLE, ALE, WE, RE, IO_oe, Din_out, Din_oe, Din_in, RB;
    logic [3:0]  IO_out;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef BUSY_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    always #5 clk = ~clk;

    rram_host_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .CE(CE), .CLE(CLE), .ALE(ALE), .WE(WE), .RE(RE),
        .IO_out(IO_out), .IO_oe(IO_oe), .Din_out(Din_out), .Din_oe(Din_oe),
        .Din_in(Din_in), .RB(RB)
    );

    // Observations collected by run_txn for the test tasks to judge.
    int          obs_cycle, obs_cmd_n, obs_addr_n, obs_wbit_n, obs_re_n;
    logic        obs_err, obs_ce_bad, obs_proto_bad, obs_din_oe_seen;
    logic [31:0] obs_rdata, obs_wbits;
    logic [7:0]  obs_cmd;
    logic [11:0] obs_addr;

    // Issue one request, play the device side, and log what the pins did until rsp_valid.
    task automatic run_txn(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                           input logic [31:0] rd_model, input int rb_lo_from,
                           input int rb_lo_len, input int max_cycles);
        int   n;
        logic prev_we, prev_re, prev_din;
        obs_cycle = 0; obs_cmd_n = 0; obs_addr_n = 0; obs_wbit_n = 0; obs_re_n = 0;
        obs_err = 1'b0; obs_ce_bad = 1'b0; obs_proto_bad = 1'b0; obs_din_oe_seen = 1'b0;
        obs_rdata = 32'd0; obs_wbits = 32'd0; obs_cmd = 8'd0; obs_addr = 12'd0;
        prev_we = 1'b0; prev_re = 1'b0; prev_din = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        @(posedge clk);
        n = 0;
        while (obs_cycle == 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
            req_valid = 1'b0;
            if ((WE && RE) || (IO_oe && Din_oe) || (WE && prev_we) || (RE && prev_re))
                obs_proto_bad = 1'b1;
            if (Din_oe) obs_din_oe_seen = 1'b1;
            if (WE && CLE) begin
                obs_cmd = {obs_cmd[3:0], IO_out};
                obs_cmd_n++;
            end
            if (WE && ALE) begin
                obs_addr = {obs_addr[7:0], IO_out};
                obs_addr_n++;
            end
            if (WE && Din_oe) begin
                if (Din_out !== prev_din) obs_proto_bad = 1'b1;
                obs_wbits = {obs_wbits[30:0], Din_out};
                obs_wbit_n++;
            end
            if (RE && obs_re_n < 32) begin
                Din_in = rd_model[31 - obs_re_n];
                obs_re_n++;
            end else begin
                Din_in = 1'b0;
            end
            if (rsp_valid) begin
                obs_cycle = n;
                obs_err   = rsp_err;
                obs_rdata = rsp_rdata;
            end else if (CE !== 1'b0) begin
                obs_ce_bad = 1'b1;
            end
            RB = (n >= rb_lo_from && n < rb_lo_from + rb_lo_len) ? 1'b0 : 1'b1;
            prev_we = WE; prev_re = RE; prev_din = Din_out;
        end
        RB = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b1;
        req_addr = 12'h5A5; req_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({CE, CLE, ALE, WE, RE, IO_oe, Din_oe, IO_out, Din_out, req_ready, rsp_valid, rsp_err}
                !== 16'b1_00000_0_0000_0_1_0_0) begin
                n_bad++;
                $display("FAIL reset_pins[%0d]: got CE=%b CLE=%b ALE=%b WE=%b RE=%b IO_oe=%b Din_oe=%b IO=%h Dout=%b rdy=%b vld=%b err=%b, expected CE=1 rdy=1 rest 0",
                         i, CE, CLE, ALE, WE, RE, IO_oe, Din_oe, IO_out, Din_out, req_ready, rsp_valid, rsp_err);
            end
        end
        n_cmp++;
        if (rsp_rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata);
        end
        rst_n = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (CE !== 1'b1 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_no_accept: got CE=%b req_ready=%b expected 1 1", CE, req_ready);
        end
    endtask

    task automatic test_write;
        run_txn(1'b1, 12'h081, 32'hA5D6_ACB5, 32'd0, 0, 0, 200);
        n_cmp++;
        if (obs_cycle !== 81) begin n_bad++; $display("FAIL write_latency: got %0d expected 81", obs_cycle); end
        n_cmp++;
        if (obs_cmd_n !== 2 || obs_cmd !== 8'h42) begin
            n_bad++; $display("FAIL write_cmds: got %0d nibbles %h expected 2 nibbles 42", obs_cmd_n, obs_cmd);
        end
        n_cmp++;
        if (obs_addr_n !== 3 || obs_addr !== 12'h081) begin
            n_bad++; $display("FAIL write_addr: got %0d nibbles %h expected 3 nibbles 081", obs_addr_n, obs_addr);
        end
        n_cmp++;
        if (obs_wbit_n !== 32 || obs_wbits !== 32'hA5D6_ACB5) begin
            n_bad++; $display("FAIL write_data: got %0d bits %h expected 32 bits a5d6acb5", obs_wbit_n, obs_wbits);
        end
        n_cmp++;
        if (obs_err !== 1'b0 || obs_re_n !== 0) begin
            n_bad++; $display("FAIL write_err_re: got err=%b re=%0d expected 0 0", obs_err, obs_re_n);
        end
        n_cmp++;
        if (obs_proto_bad !== 1'b0 || obs_ce_bad !== 1'b0) begin
            n_bad++; $display("FAIL write_protocol: got proto=%b ce=%b expected 0 0", obs_proto_bad, obs_ce_bad);
        end
    endtask

    // Issued straight after the write's DONE cycle, so it also checks back-to-back acceptance.
    task automatic test_back_to_back_read;
        run_txn(1'b0, 12'hFFF, 32'd0, 32'h1234_5678, 0, 0, 200);
        n_cmp++;
        if (obs_cycle !== 78) begin n_bad++; $display("FAIL read_latency: got %0d expected 78", obs_cycle); end
        n_cmp++;
        if (obs_rdata !== 32'h1234_5678 || obs_err !== 1'b0) begin
            n_bad++; $display("FAIL read_data: got %h err=%b expected 12345678 err=0", obs_rdata, obs_err);
        end
        n_cmp++;
        if (obs_cmd_n !== 1 || obs_cmd[3:0] !== 4'b0001 || obs_addr_n !== 3 || obs_addr !== 12'hFFF) begin
            n_bad++; $display("FAIL read_cmd_addr: got cmd %0d/%h addr %0d/%h expected 1/1 3/fff",
                              obs_cmd_n, obs_cmd[3:0], obs_addr_n, obs_addr);
        end
        n_cmp++;
        if (obs_re_n !== 32 || obs_din_oe_seen !== 1'b0 || obs_proto_bad !== 1'b0 || obs_ce_bad !== 1'b0) begin
            n_bad++; $display("FAIL read_protocol: got re=%0d din_oe=%b proto=%b ce=%b expected 32 0 0 0",
                              obs_re_n, obs_din_oe_seen, obs_proto_bad, obs_ce_bad);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || CE !== 1'b1 || req_ready !== 1'b1 || rsp_rdata !== 32'h1234_5678) begin
            n_bad++; $display("FAIL read_after_done: got vld=%b CE=%b rdy=%b rdata=%h expected 0 1 1 12345678",
                              rsp_valid, CE, req_ready, rsp_rdata);
        end
    endtask

    // RB held low for cycles 78..97 (from the confirm WE pulse), 18 cycles beyond the guard.
    task automatic test_write_busy;
        run_txn(1'b1, 12'h3C5, 32'h0F1E_2D3C, 32'd0, 78, 20, 300);
        n_cmp++;
        if (obs_cycle !== 99) begin n_bad++; $display("FAIL busy_latency: got %0d expected 99", obs_cycle); end
        n_cmp++;
        if (obs_ce_bad !== 1'b0 || obs_proto_bad !== 1'b0) begin
            n_bad++; $display("FAIL busy_ce_low: got ce=%b proto=%b expected 0 0", obs_ce_bad, obs_proto_bad);
        end
        n_cmp++;
        if (obs_wbits !== 32'h0F1E_2D3C || obs_addr !== 12'h3C5 || obs_err !== 1'b0) begin
            n_bad++; $display("FAIL busy_payload: got data %h addr %h err=%b expected 0f1e2d3c 3c5 0",
                              obs_wbits, obs_addr, obs_err);
        end
    endtask

    task automatic test_reset_mid;
        logic seen_vld;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h123; req_wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (53) @(negedge clk);
        n_cmp++;
        if (Din_oe !== 1'b1 || Din_out !== 1'b1) begin
            n_bad++; $display("FAIL mid_in_wdata: got Din_oe=%b Din_out=%b expected 1 1", Din_oe, Din_out);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (CE !== 1'b1 || Din_oe !== 1'b0 || WE !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_reset_pins: got CE=%b Din_oe=%b WE=%b vld=%b rdy=%b expected 1 0 0 0 1",
                              CE, Din_oe, WE, rsp_valid, req_ready);
        end
        rst_n = 1'b1;
        seen_vld = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || CE !== 1'b1) seen_vld = 1'b1;
        end
        n_cmp++;
        if (seen_vld !== 1'b0) begin n_bad++; $display("FAIL mid_no_response: got activity=1 expected 0"); end
        run_txn(1'b0, 12'h2A7, 32'd0, 32'h8000_0001, 0, 0, 200);
        n_cmp++;
        if (obs_cycle !== 78 || obs_rdata !== 32'h8000_0001 || obs_addr !== 12'h2A7) begin
            n_bad++; $display("FAIL mid_follow_read: got cyc=%0d data=%h addr=%h expected 78 80000001 2a7",
                              obs_cycle, obs_rdata, obs_addr);
        end
    endtask

`ifdef BUSY_TIMEOUT_EN
    task automatic test_timeout;
        run_txn(1'b0, 12'h100, 32'd0, 32'hFFFF_FFFF, 1, 100000, 100);
        n_cmp++;
        if (obs_cycle !== 28 || obs_err !== 1'b1) begin
            n_bad++; $display("FAIL timeout_rsp: got cyc=%0d err=%b expected 28 1", obs_cycle, obs_err);
        end
        n_cmp++;
        if (obs_re_n !== 0 || obs_rdata !== 32'h8000_0001) begin
            n_bad++; $display("FAIL timeout_no_read: got re=%0d rdata=%h expected 0 80000001", obs_re_n, obs_rdata);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 12'd0; req_wdata = 32'd0;
        Din_in = 1'b0; RB = 1'b1;
        test_reset;
        test_write;
        test_back_to_back_read;
        test_write_busy;
        test_reset_mid;
`ifdef BUSY_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
